// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle add/sub/logic ops, iterative one-bit-per-cycle shifts.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, 1+N cycles for a shift by N.
// Backpressure: in_ready only in IDLE; DONE holds result/zero frozen until out_ready.
module alu_exec_unit #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q;
    logic [XLEN-1:0]   work_q, work_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              left_q, left_d;
    logic [XLEN-1:0]   work_shifted;
    logic [SHW-1:0]    amt;

    assign amt       = operand_b[SHW-1:0];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // One-bit step of the working register in the latched direction.
    assign work_shifted = left_q ? {work_q[XLEN-2:0], 1'b0} : {1'b0, work_q[XLEN-1:1]};

    // Next-state and datapath: decode on accept, step shifts, retire on out_ready.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    // Codes with x/z bits fall to the default arm and yield zero.
                    case (alu_control)
                        OP_ADD: result_d = operand_a + operand_b;
                        OP_SUB: result_d = operand_a - operand_b;
                        OP_AND: result_d = operand_a & operand_b;
                        OP_OR:  result_d = operand_a | operand_b;
                        OP_XOR: result_d = operand_a ^ operand_b;
                        OP_SRL, OP_SLL: begin
                            if (amt == '0) begin
                                result_d = operand_a;
                            end else begin
                                work_d  = operand_a;
                                cnt_d   = amt;
                                left_d  = (alu_control == OP_SLL);
                                state_d = SHIFT;
                            end
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            SHIFT: begin
                work_d = work_shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d = work_shifted;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; zero flag is registered alongside result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= (result_d == '0);
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, hand-written corner sequences,
// and randomized ops against a behavioural model.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_control = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_exec_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ez;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model straight from the opcode table.
    function automatic logic [31:0] ref_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if ($isunknown(c)) return 32'h0;
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a >> b[4:0];
            3'd6: return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] c, input logic [31:0] b);
        if (!$isunknown(c) && (c == 3'd5 || c == 3'd6)) return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // Issue one op from IDLE, measure latency, capture outputs, then retire it.
    task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic z);
        alu_control = c;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        alu_control = 3'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL timeout waiting for out_valid actual=0 expected=1");
        end
        res = result;
        z   = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t        vecs[10];
    int          lat;
    logic [31:0] res;
    logic        z;
    logic [31:0] held;
    logic [2:0]  cz;

    initial begin
        vecs[0] = '{3'b000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1};
        vecs[1] = '{3'b001, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1};
        vecs[2] = '{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[3] = '{3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1};
        vecs[4] = '{3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1};
        vecs[5] = '{3'b101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 5};
        vecs[6] = '{3'b110, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 32};
        vecs[7] = '{3'b110, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1};
        vecs[8] = '{3'b111, 32'h5,         32'h6,         32'h0,         1'b1, 1};
        vecs[9] = '{3'b101, 32'h0000_0001, 32'h0000_0003, 32'h0,         1'b1, 4};

        // Reset state while rst is held.
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_in_ready",  32'(in_ready),  32'h1);
        chk("reset_result",    result,         32'h0);
        chk("reset_zero",      32'(zero),      32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].c, vecs[i].a, vecs[i].b, lat, res, z);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].ez));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_retire", i), {30'h0, out_valid, in_ready}, 32'h1);
        end

        // Undriven opcode: expectation follows what the simulator holds for 3'bzzz.
        cz = 3'bzzz;
        do_op(cz, 32'h5, 32'h6, lat, res, z);
        chk("opz_result",  res,       ref_res(cz, 32'h5, 32'h6));
        chk("opz_zero",    32'(z),    32'(ref_res(cz, 32'h5, 32'h6) == 32'h0));
        chk("opz_latency", 32'(lat),  32'h1);

        // Reset in the middle of a shift; nonzero prior result makes the clear visible.
        do_op(3'b000, 32'd7, 32'd8, lat, res, z);
        alu_control = 3'b110; operand_a = 32'h1; operand_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("midshift_rst_out_valid", 32'(out_valid), 32'h0);
        chk("midshift_rst_in_ready",  32'(in_ready),  32'h1);
        chk("midshift_rst_result",    result,         32'h0);
        chk("midshift_rst_zero",      32'(zero),      32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(3'b000, 32'd2, 32'd3, lat, res, z);
        chk("post_rst_add", res, 32'd5);
        chk("post_rst_add_latency", 32'(lat), 32'h1);

        // Back-pressure: DONE stalled for 10 cycles while upstream toggles another op.
        alu_control = 3'b000; operand_a = 32'd10; operand_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_done", 32'(out_valid), 32'h1);
        held = result;
        chk("bp_result", held, 32'd30);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; alu_control = 3'b001; operand_a = 32'd100; operand_b = 32'd1;
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_result", k), result, 32'd30);
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'h0);
            chk($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'h1);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_retire_out_valid", 32'(out_valid), 32'h0);
        chk("bp_retire_in_ready",  32'(in_ready),  32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_out_valid", 32'(out_valid), 32'h1);
        chk("bp_next_result",    result,         32'd99);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized ops against the model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  rc;
            logic [31:0] ra, rb;
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_op(rc, ra, rb, lat, res, z);
            chk($sformatf("rnd%0d_op%0d_result", n, rc), res, ref_res(rc, ra, rb));
            chk($sformatf("rnd%0d_zero", n), 32'(z), 32'(ref_res(rc, ra, rb) == 32'h0));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ref_lat(rc, rb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
